alu_ctrl_mc: RTL
================

Name: alu_ctrl_mc

Overview:
Parametrised, multi-cycle successor to the combinational ALU control decoder. It decodes alu_op/funct into a 4-bit aluctrl code and executes the operation on WIDTH-bit operands. Single-cycle ops return a result in one cycle. SLL/SRL run as one-bit-per-cycle shifts and MUL as an iterative shift-add. Sits in the EX stage behind a valid/ready handshake so the datapath can stall on multi-cycle ops.

Parameters:
WIDTH, 32, operand/result width (>=8)
SHAMT_W, 5, shift-amount width; must equal clog2(WIDTH)
MUL_EN, 1, 1 = MUL funct supported; 0 = MUL decoded as illegal

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  block can accept request
alu_op  input  3  main-decoder op class
funct  input  6  R-type function field
shamt  input  SHAMT_W  shift amount (SLL/SRL)
a  input  WIDTH  operand rs
b  input  WIDTH  operand rt / immediate
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  ALU result
zero  output  1  result == 0
aluctrl  output  4  control code of the completed op
illegal  output  1  completed op was undecodable
busy  output  1  multi-cycle op in progress

Behaviour:
- Reset (rst_n low, async): state IDLE; out_valid, result, zero, aluctrl, illegal, busy all 0; in_ready 0 while rst_n low. Reset mid-op aborts it with no out_valid.
- alu_op decode: 000 ADD (lw/sw/addi); 001 SUB (beq); 010 R-type via funct; 011 AND (andi); 100 OR (ori); 101 SLT (slti); 110/111 illegal.
- funct decode (alu_op=010):
  - 100100 AND
  - 100101 OR
  - 100000 ADD
  - 100010 SUB
  - 101010 SLT
  - 100111 NOR
  - 000000 SLL
  - 000010 SRL
  - 011000 MUL (only if MUL_EN=1)
  - anything else is illegal.
- aluctrl codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100, SLL 1000, SRL 1001, MUL 1010. Illegal reports 0000.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - SLT is signed two's-complement; result is 1 or 0, zero-extended.
  - SLL/SRL shift b (logical) by shamt.
  - MUL yields the low WIDTH bits of a*b (unsigned).
- Handshake:
  - in_ready = rst_n & (state==IDLE) & (!out_valid | out_ready).
  - A request is accepted on an edge where in_valid & in_ready.
  - out_valid stays high, and result/zero/aluctrl/illegal stay stable, until an edge with out_ready=1.
  - Accept-while-draining is allowed: the new result replaces the old one with no bubble for 1-cycle ops.
- FSM states: IDLE, SHIFT, MUL.
  - IDLE, accept of a 1-cycle op (ADD/SUB/AND/OR/NOR/SLT/illegal, or SLL/SRL with shamt=0): result registered at the accept edge; out_valid high the next cycle (latency 1).
  - IDLE, accept of SLL/SRL with shamt=k>0: acc<=b, cnt<=k, go to SHIFT.
  - SHIFT: each edge shifts acc by 1 and decrements cnt. On the edge where cnt goes 1->0, result<=shifted acc, out_valid<=1, return to IDLE. Latency 1+k edges.
  - IDLE, accept of MUL: multiplicand<=a, multiplier<=b, prod<=0, cnt<=WIDTH, go to MUL.
  - MUL: each edge adds the multiplicand to prod if multiplier LSB=1, then shifts multiplicand left and multiplier right. The final iteration writes result, sets out_valid and returns to IDLE. Latency 1+WIDTH edges.
- busy = (state != IDLE).
- Inputs are sampled only at the accept edge; changes during SHIFT/MUL are ignored.
- out_ready is ignored while out_valid=0.
- zero is computed from the final registered result.

Test Plan:
- Reset: assert rst_n=0 mid-MUL -> immediately out_valid=0, busy=0, result=0, in_ready=0. Release reset -> in_ready=1 the next cycle, and the aborted op never completes.
- alu_op=010, funct=100010, a=5, b=5, out_ready=1 -> one cycle later out_valid=1, result=0, zero=1, aluctrl=0110. With alu_op=101, a=32'hFFFFFFFF, b=1 -> result=1 (signed SLT).
- alu_op=010, funct=000000, shamt=4, b=32'h0000000F -> busy for 4 cycles, in_ready=0 throughout. out_valid rises 5 edges after accept with result=32'h000000F0, aluctrl=1000. With shamt=0, result=b after 1 cycle.
- MUL, a=7, b=6, WIDTH=32 -> out_valid after 33 edges, result=42, aluctrl=1010. Repeat with a=b=32'hFFFFFFFF -> result=1. With MUL_EN=0 the same funct gives illegal=1, result=0, latency 1.
- Backpressure: out_ready=0 for 3 cycles after an ADD completes -> result held, in_ready=0. Raise out_ready with in_valid=1 -> same-edge drain+accept, and the next result follows with no bubble.
- Illegal: alu_op=111, and alu_op=010 with funct=111111 -> illegal=1, aluctrl=0000, result=0, zero=1, latency 1.

Source files
------------

// File: rtl/alu_ctrl_mc_if.sv
// Request/response bundle for the multi-cycle ALU control block.
// The master issues operations and the slave returns results over valid/ready.
interface alu_ctrl_mc_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         alu_op;
  logic [5:0]         funct;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   result;
  logic               zero;
  logic [3:0]         aluctrl;
  logic               illegal;
  logic               busy;

  modport master (
    output in_valid, alu_op, funct, shamt, a, b, out_ready,
    input  in_ready, out_valid, result, zero, aluctrl, illegal, busy
  );

  modport slave (
    input  in_valid, alu_op, funct, shamt, a, b, out_ready,
    output in_ready, out_valid, result, zero, aluctrl, illegal, busy
  );
endinterface

// File: rtl/alu_ctrl_mc.sv
// ALU control decoder plus execution unit; shifts and multiply are iterative.
// state | meaning
// IDLE  | waiting for a request, single-cycle ops complete from here
// SHIFT | one-bit-per-cycle logical shift of acc, cnt bits remaining
// MUL   | shift-add multiply, cnt iterations remaining
module alu_ctrl_mc #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter bit MUL_EN  = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  alu_ctrl_mc_if.slave bus
);
  localparam int CW = SHAMT_W + 1;
  localparam logic [3:0] C_AND = 4'b0000, C_OR  = 4'b0001, C_ADD = 4'b0010,
                         C_SUB = 4'b0110, C_SLT = 4'b0111, C_NOR = 4'b1100,
                         C_SLL = 4'b1000, C_SRL = 4'b1001, C_MUL = 4'b1010;

  typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [WIDTH-1:0] prod_q, prod_d, res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       op_q, op_d, ctrl_q, ctrl_d;
  logic             out_valid_q, out_valid_d, zero_q, zero_d, ill_q, ill_d;

  logic [3:0]       dec_ctrl;
  logic             dec_ill;
  logic [WIDTH-1:0] one_val, shifted, sum;
  logic             accept;

  always_comb begin
    dec_ctrl = C_AND;
    dec_ill  = 1'b0;
    case (bus.alu_op)
      3'b000: dec_ctrl = C_ADD;
      3'b001: dec_ctrl = C_SUB;
      3'b010: begin
        case (bus.funct)
          6'b100100: dec_ctrl = C_AND;
          6'b100101: dec_ctrl = C_OR;
          6'b100000: dec_ctrl = C_ADD;
          6'b100010: dec_ctrl = C_SUB;
          6'b101010: dec_ctrl = C_SLT;
          6'b100111: dec_ctrl = C_NOR;
          6'b000000: dec_ctrl = C_SLL;
          6'b000010: dec_ctrl = C_SRL;
          6'b011000: if (MUL_EN) dec_ctrl = C_MUL; else dec_ill = 1'b1;
          default:   dec_ill = 1'b1;
        endcase
      end
      3'b011:  dec_ctrl = C_AND;
      3'b100:  dec_ctrl = C_OR;
      3'b101:  dec_ctrl = C_SLT;
      default: dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    one_val = '0;
    case (dec_ctrl)
      C_AND:   one_val = bus.a & bus.b;
      C_OR:    one_val = bus.a | bus.b;
      C_ADD:   one_val = bus.a + bus.b;
      C_SUB:   one_val = bus.a - bus.b;
      C_SLT:   one_val = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      C_NOR:   one_val = ~(bus.a | bus.b);
      C_SLL:   one_val = bus.b << bus.shamt;
      C_SRL:   one_val = bus.b >> bus.shamt;
      default: one_val = '0;
    endcase
    if (dec_ill) one_val = '0;
  end

  assign bus.in_ready = rst_n & (state_q == IDLE) & (~out_valid_q | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  assign shifted      = (op_q == C_SLL) ? (acc_q << 1) : (acc_q >> 1);
  assign sum          = prod_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    prod_d      = prod_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    res_d       = res_q;
    zero_d      = zero_q;
    ctrl_d      = ctrl_q;
    ill_d       = ill_q;
    out_valid_d = out_valid_q & ~bus.out_ready;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!dec_ill && (dec_ctrl == C_SLL || dec_ctrl == C_SRL) && bus.shamt != '0) begin
            acc_d   = bus.b;
            cnt_d   = {1'b0, bus.shamt};
            op_d    = dec_ctrl;
            state_d = SHIFT;
          end else if (!dec_ill && dec_ctrl == C_MUL) begin
            mcand_d  = bus.a;
            mplier_d = bus.b;
            prod_d   = '0;
            cnt_d    = CW'(WIDTH);
            state_d  = MUL;
          end else begin
            res_d       = one_val;
            zero_d      = (one_val == '0);
            ctrl_d      = dec_ctrl;
            ill_d       = dec_ill;
            out_valid_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        acc_d = shifted;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          res_d       = shifted;
          zero_d      = (shifted == '0);
          ctrl_d      = op_q;
          ill_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      MUL: begin
        prod_d   = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          res_d       = sum;
          zero_d      = (sum == '0);
          ctrl_d      = C_MUL;
          ill_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
      op_q        <= C_AND;
      res_q       <= '0;
      zero_q      <= 1'b0;
      ctrl_q      <= C_AND;
      ill_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      res_q       <= res_d;
      zero_q      <= zero_d;
      ctrl_q      <= ctrl_d;
      ill_q       <= ill_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = res_q;
  assign bus.zero      = zero_q;
  assign bus.aluctrl   = ctrl_q;
  assign bus.illegal   = ill_q;
  assign bus.busy      = (state_q != IDLE);
endmodule
